pipe_e_stage: RTL and testbench

PIPE_E_STAGE -- requirements
Module: pipe_E_stage

---
 rtl/pipe_e_stage_pkg.sv | 36 +++
 rtl/pipe_e_stage_alu.sv | 30 +++
 rtl/pipe_e_stage.sv | 81 ++++++++
 tb/tb_pipe_e_stage.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_e_stage_pkg.sv
// Shared CPU definitions: ALU operation codes used by the control unit and
// the execute stage, plus the layout of the D/E pipeline register.
package pipe_e_stage_pkg;

  // Low three bits select the operation; bit 3 is don't-care for these.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b110;

  // Shift codes need all four bits.
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Contents of the D/E register.
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        jal;
    logic        aluimm;
    logic        shift;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } de_reg_t;

endpackage

// File: rtl/pipe_e_stage_alu.sv
// Execute-stage ALU with the barrel shifter folded in. Shifts take the
// amount from a[4:0] and the data from b.
module alu
  import pipe_e_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r
);

  // Decode on the low bits; shift codes also qualify on bit 3, and any
  // code not in the table yields zero.
  always_comb begin
    r = '0;
    case (aluc[2:0])
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_LUI: r = {b[15:0], 16'h0000};
      3'b011:  r = (aluc == ALU_SLL) ? (b << a[4:0]) : 32'h0;
      3'b111:  r = (aluc == ALU_SRA) ? 32'($signed(b) >>> a[4:0])
                                     : (b >> a[4:0]);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/pipe_e_stage.sv
// Execute stage: D/E pipeline register, ALU operand selection, jal link
// override and a saturating count of load-use bubbles.
module pipe_e_stage
  import pipe_e_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wpcir,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             djal,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic [3:0]       daluc,
  input  logic [4:0]       drn,
  input  logic [31:0]      dpc4,
  input  logic [31:0]      da,
  input  logic [31:0]      db,
  input  logic [31:0]      dimm,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [4:0]       ern,
  output logic [31:0]      ealu,
  output logic [31:0]      eb,
  output logic [CNT_W-1:0] ebubbles
);

  de_reg_t     de;
  logic [31:0] alu_a, alu_b, alu_r;

  // D/E register loads every cycle; a stall squashes only the side-effecting
  // controls so the bubble does nothing downstream.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      de <= '0;
    end else begin
      de.wreg   <= dwreg  & wpcir;
      de.m2reg  <= dm2reg & wpcir;
      de.wmem   <= dwmem  & wpcir;
      de.jal    <= djal   & wpcir;
      de.aluimm <= daluimm;
      de.shift  <= dshift;
      de.aluc   <= daluc;
      de.rn     <= drn;
      de.pc4    <= dpc4;
      de.a      <= da;
      de.b      <= db;
      de.imm    <= dimm;
    end
  end

  // Bubble counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      ebubbles <= '0;
    else if (!wpcir && (ebubbles != '1))
      ebubbles <= ebubbles + CNT_W'(1);
  end

  assign alu_a = de.shift  ? de.imm : de.a;
  assign alu_b = de.aluimm ? de.imm : de.b;

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .aluc (de.aluc),
    .r    (alu_r)
  );

  assign ewreg  = de.wreg;
  assign em2reg = de.m2reg;
  assign ewmem  = de.wmem;
  assign eb     = de.b;
  assign ern    = de.jal ? LINK_REG : de.rn;
  assign ealu   = de.jal ? (de.pc4 + 32'd4) : alu_r;

endmodule

// File: tb/tb_pipe_e_stage.sv
// Directed bench for pipe_e_stage: a vector table for single-cycle behaviour
// plus hand sequences for async reset, reset during stall and saturation.
module tb_pipe_e_stage;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic             wpcir, dwreg, dm2reg, dwmem, djal, daluimm, dshift;
  logic [3:0]       daluc;
  logic [4:0]       drn;
  logic [31:0]      dpc4, da, db, dimm;
  logic             ewreg, em2reg, ewmem;
  logic [4:0]       ern;
  logic [31:0]      ealu, eb;
  logic [CNT_W-1:0] ebubbles;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        wpcir, wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] pc4, a, b, imm;
    logic        x_wreg, x_m2reg, x_wmem;
    logic [4:0]  x_rn;
    logic [31:0] x_alu, x_eb;
    logic [3:0]  x_bub;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [0:NV-1];

  pipe_e_stage #(.CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .wpcir(wpcir),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
    .daluimm(daluimm), .dshift(dshift), .daluc(daluc), .drn(drn),
    .dpc4(dpc4), .da(da), .db(db), .dimm(dimm),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .ealu(ealu), .eb(eb), .ebubbles(ebubbles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wpcir = v.wpcir; dwreg = v.wreg; dm2reg = v.m2reg; dwmem = v.wmem;
    djal = v.jal; daluimm = v.aluimm; dshift = v.shift; daluc = v.aluc;
    drn = v.rn; dpc4 = v.pc4; da = v.a; db = v.b; dimm = v.imm;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ewreg"},  32'(ewreg),    32'd0);
    chk({tag, ".em2reg"}, 32'(em2reg),   32'd0);
    chk({tag, ".ewmem"},  32'(ewmem),    32'd0);
    chk({tag, ".ern"},    32'(ern),      32'd0);
    chk({tag, ".ealu"},   ealu,          32'd0);
    chk({tag, ".eb"},     eb,            32'd0);
    chk({tag, ".ebub"},   32'(ebubbles), 32'd0);
  endtask

  initial begin
    //        wp wr m2 wm jl im sh aluc     rn     pc4           a             b             imm           xwr xm2 xwm xrn    xalu          xeb           xbub
    vecs[0]  = '{1,1,0,0,0,0,0,4'b0000,5'd3, 32'h0,        32'd5,        32'd7,        32'h0,        1,0,0,5'd3, 32'd12,       32'd7,        4'd0};
    vecs[1]  = '{1,1,0,0,0,0,0,4'b0100,5'd4, 32'h0,        32'd5,        32'd7,        32'h0,        1,0,0,5'd4, 32'hFFFFFFFE, 32'd7,        4'd0};
    vecs[2]  = '{1,0,1,0,0,0,0,4'b0001,5'd5, 32'h0,        32'h0000F0F0, 32'h0000FF00, 32'h0,        0,1,0,5'd5, 32'h0000F000, 32'h0000FF00, 4'd0};
    vecs[3]  = '{1,0,0,1,0,0,0,4'b1101,5'd6, 32'h0,        32'h0000F0F0, 32'h00000F00, 32'h0,        0,0,1,5'd6, 32'h0000FFF0, 32'h00000F00, 4'd0};
    vecs[4]  = '{1,1,0,0,0,0,0,4'b0010,5'd7, 32'h0,        32'h0000FF00, 32'h00000FF0, 32'h0,        1,0,0,5'd7, 32'h0000F0F0, 32'h00000FF0, 4'd0};
    vecs[5]  = '{1,1,0,0,0,1,0,4'b0110,5'd8, 32'h0,        32'h0,        32'h00000055, 32'h00001234, 1,0,0,5'd8, 32'h12340000, 32'h00000055, 4'd0};
    vecs[6]  = '{1,1,0,0,0,0,1,4'b1111,5'd9, 32'h0,        32'h0,        32'h80000000, 32'd4,        1,0,0,5'd9, 32'hF8000000, 32'h80000000, 4'd0};
    vecs[7]  = '{1,1,0,0,0,0,1,4'b0111,5'd10,32'h0,        32'h0,        32'h80000000, 32'd4,        1,0,0,5'd10,32'h08000000, 32'h80000000, 4'd0};
    vecs[8]  = '{1,1,0,0,0,0,0,4'b0011,5'd11,32'h0,        32'd8,        32'd1,        32'h0,        1,0,0,5'd11,32'h00000100, 32'd1,        4'd0};
    vecs[9]  = '{1,1,0,0,1,0,0,4'b0000,5'd0, 32'h00000100, 32'd1,        32'd2,        32'h0,        1,0,0,5'd31,32'h00000104, 32'd2,        4'd0};
    vecs[10] = '{1,1,0,0,0,0,0,4'b1011,5'd12,32'h0,        32'd9,        32'd3,        32'h0,        1,0,0,5'd12,32'h0,        32'd3,        4'd0};
    vecs[11] = '{1,1,0,0,0,0,0,4'b0000,5'd13,32'h0,        32'hFFFFFFFF, 32'd2,        32'h0,        1,0,0,5'd13,32'd1,        32'd2,        4'd0};
    vecs[12] = '{1,1,0,0,0,0,0,4'b1000,5'd14,32'h0,        32'd3,        32'd4,        32'h0,        1,0,0,5'd14,32'd7,        32'd4,        4'd0};
    vecs[13] = '{1,1,0,0,0,1,0,4'b0000,5'd15,32'h0,        32'd10,       32'd99,       32'hFFFFFFFF, 1,0,0,5'd15,32'd9,        32'd99,       4'd0};
    vecs[14] = '{0,1,1,1,0,0,0,4'b0000,5'd16,32'h0,        32'd1,        32'd2,        32'h0,        0,0,0,5'd16,32'd3,        32'd2,        4'd1};
    vecs[15] = '{0,1,0,0,1,0,0,4'b0000,5'd5, 32'h00000200, 32'd1,        32'd1,        32'h0,        0,0,0,5'd5, 32'd2,        32'd1,        4'd2};

    // Reset with stall requested; outputs must all read zero.
    resetn = 1'b0;
    drive(vecs[14]);
    repeat (2) @(posedge clock);
    #1 chk_all_zero("reset");

    // Release between edges and run the table.
    @(negedge clock) resetn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.ewreg", i),  32'(ewreg),    32'(vecs[i].x_wreg));
      chk($sformatf("v%0d.em2reg", i), 32'(em2reg),   32'(vecs[i].x_m2reg));
      chk($sformatf("v%0d.ewmem", i),  32'(ewmem),    32'(vecs[i].x_wmem));
      chk($sformatf("v%0d.ern", i),    32'(ern),      32'(vecs[i].x_rn));
      chk($sformatf("v%0d.ealu", i),   ealu,          vecs[i].x_alu);
      chk($sformatf("v%0d.eb", i),     eb,            vecs[i].x_eb);
      chk($sformatf("v%0d.ebub", i),   32'(ebubbles), 32'(vecs[i].x_bub));
    end

    // Async reset mid-cycle while stalled: outputs clear before next edge.
    drive(vecs[14]);
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 chk_all_zero("async_rst");

    // Stall held during reset is discarded; first edge after release loads live inputs.
    @(negedge clock) begin
      resetn = 1'b1;
      drive(vecs[0]);
    end
    @(posedge clock);
    #1;
    chk("post_rst.ewreg", 32'(ewreg),    32'd1);
    chk("post_rst.ealu",  ealu,          32'd12);
    chk("post_rst.ebub",  32'(ebubbles), 32'd0);

    // Saturation: 15 stalls reach all-ones, 5 more must not wrap.
    drive(vecs[14]);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 1)  chk("sat.first",  32'(ebubbles), 32'd1);
      if (i == 14) chk("sat.14",     32'(ebubbles), 32'd14);
      if (i == 15) chk("sat.15",     32'(ebubbles), 32'd15);
    end
    chk("sat.20", 32'(ebubbles), 32'd15);
    chk("sat.ewreg", 32'(ewreg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
